network_run_ctrl: RTL
=====================

# network_run_ctrl

Run controller for the spiking pixel-classification network. A start pulse latches the pixel vector and clears the network. The controller then enables the network for a fixed number of cycles and counts output spikes per class. At the end it reports the winning class, or a "no spike" result. It replaces the single-neuron, gated-clock run wrapper: it handles CLASSES output neurons, drives a clock enable instead of a gated clock, and provides busy/done/abort handshaking.

## Interface

Parameters:
- HEIGHT, 7, pixel inputs fed to the network
- CLASSES, 4, output neurons/classes (≥2)
- RUN_CYCLES, 7168, enabled network cycles per run (HEIGHT·2^(WIDTH+2) for WIDTH=8); ≥1
- CNT_W, 8, per-class spike counter width

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  run request, sampled each posedge
- abort  in  1  cancel current run
- pixels  in  HEIGHT  pixel vector, latched on accepted start
- spikes  in  CLASSES  network output spikes, one per class
- net_pixels  out  HEIGHT  latched pixels to network
- net_en  out  1  network clock enable
- net_rst  out  1  synchronous active-high clear to network
- busy  out  1  run in progress
- done  out  1  one-cycle pulse, results valid
- winner  out  $clog2(CLASSES)  index of class with most spikes
- no_spike  out  1  all counters zero at end of run
- counts  out  CLASSES·CNT_W  per-class counters, class i at [i·CNT_W +: CNT_W]

## Operation

- States: IDLE, CLEAR, RUN, DECIDE, DONE.
- IDLE/DONE: start=1 → CLEAR; pixels latched to net_pixels; counters and cycle counter zeroed. A start in DONE is accepted the same way (back-to-back runs).
- CLEAR: one cycle; net_rst=1, net_en=0 → RUN.
- RUN: net_en=1. Each cycle, counter i increments when spikes[i]=1. Counters saturate at 2^CNT_W−1, with no wrap. The cycle counter is width $clog2(RUN_CYCLES+1). After RUN_CYCLES RUN cycles → DECIDE.
- DECIDE: one cycle; registers winner = argmax(counts). Ties go to the lowest index. no_spike=1 if all counts=0, in which case winner=0. → DONE.
- DONE: done=1 in the first DONE cycle only. winner, no_spike and counts hold until the next accepted start.
- start while busy: ignored, with no effect on the run.
- abort=1 in CLEAR/RUN/DECIDE: → IDLE next cycle. net_en=0, done not pulsed, winner=0, no_spike=0. counts keep their partial values. abort outside a run: ignored.
- abort and start in the same cycle: abort wins if busy; start wins if idle.
- spikes are ignored outside RUN.
- busy = state ∈ {CLEAR, RUN, DECIDE}.

## Timing

- Reset values (async on rst_n=0): state=IDLE, net_pixels=0, net_en=0, net_rst=1, busy=0, done=0, winner=0, no_spike=0, counts=0. Reset mid-run discards the run immediately.
- After reset release, net_rst=0 from the first posedge onward (IDLE).
- Start sampled at edge E0. Then:
  - CLEAR occupies the cycle after E0.
  - net_en=1 for exactly RUN_CYCLES cycles starting at edge E0+2.
  - DECIDE follows at E0+RUN_CYCLES+2.
  - done=1 during the cycle after edge E0+RUN_CYCLES+3.
- Latency from start to done: RUN_CYCLES+3 cycles.
- winner, no_spike and counts are stable when done=1.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

Bench settings: CLASSES=4, RUN_CYCLES=16, CNT_W=4.

- Reset: rst_n low mid-cycle → all outputs at reset values asynchronously. Release rst_n, then start pulse → done exactly 19 cycles after the start edge.
- Single winner: spikes=4'b0100 on every RUN cycle → counts[2] saturates at 15, winner=2, no_spike=0. net_en high exactly 16 cycles.
- Tie and no-spike:
  - spikes=4'b1010 every RUN cycle → winner=1.
  - Next run with spikes=0 → no_spike=1, winner=0, counts=0.
- Busy protection: second start 5 cycles into RUN with different pixels → net_pixels unchanged, done still 19 cycles after the first start.
- Abort: abort at RUN cycle 8 → IDLE next cycle, net_en=0, no done pulse. A following start runs a full fresh run with counters cleared.
- Back-to-back: start in the first DONE cycle → next cycle busy=1, net_rst=1, counts cleared, new pixels latched.

Source files
------------

// File: rtl/network_run_ctrl.sv
// Run controller for the spiking classifier: clear network, enable it, count spikes, pick a winner.
// Latency: done pulses RUN_CYCLES+3 cycles after the edge that accepts start.
// Backpressure: none; start is ignored while busy, abort cancels a run in flight.
module network_run_ctrl #(
    parameter int HEIGHT     = 7,
    parameter int CLASSES    = 4,
    parameter int RUN_CYCLES = 7168,
    parameter int CNT_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [HEIGHT-1:0]           pixels,
    input  logic [CLASSES-1:0]          spikes,
    output logic [HEIGHT-1:0]           net_pixels,
    output logic                        net_en,
    output logic                        net_rst,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(CLASSES)-1:0]  winner,
    output logic                        no_spike,
    output logic [CLASSES*CNT_W-1:0]    counts
);

    localparam int WIN_W = $clog2(CLASSES);
    localparam int CYC_W = $clog2(RUN_CYCLES + 1);

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(RUN_CYCLES);
    localparam logic [CYC_W-1:0] EN_LAST  = CYC_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_DECIDE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]                       state;
    logic [CYC_W-1:0]                 cyc_q;
    logic [CLASSES-1:0][CNT_W-1:0]    cnt_q;
    logic [WIN_W-1:0]                 best_idx;
    logic [CNT_W-1:0]                 best_val;
    logic                             any_spk;

    assign counts = cnt_q;

    // Strict '>' keeps the lowest index on ties; all-zero leaves index 0.
    always_comb begin
        best_idx = '0;
        best_val = cnt_q[0];
        any_spk  = 1'b0;
        for (int i = 0; i < CLASSES; i++) begin
            if (cnt_q[i] != '0) any_spk = 1'b1;
            if (cnt_q[i] > best_val) begin
                best_val = cnt_q[i];
                best_idx = WIN_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cyc_q      <= '0;
            net_pixels <= '0;
            net_en     <= 1'b0;
            net_rst    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            winner     <= '0;
            no_spike   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            done <= 1'b0;
            if (busy && abort) begin
                state    <= S_IDLE;
                net_en   <= 1'b0;
                net_rst  <= 1'b0;
                busy     <= 1'b0;
                winner   <= '0;
                no_spike <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        net_rst <= 1'b0;
                        if (start) begin
                            state      <= S_CLEAR;
                            net_pixels <= pixels;
                            net_rst    <= 1'b1;
                            busy       <= 1'b1;
                            cyc_q      <= '0;
                            winner     <= '0;
                            no_spike   <= 1'b0;
                            cnt_q      <= '0;
                        end
                    end
                    S_CLEAR: begin
                        state   <= S_RUN;
                        net_rst <= 1'b0;
                        net_en  <= 1'b1;
                    end
                    S_RUN: begin
                        cyc_q  <= cyc_q + 1'b1;
                        net_en <= (cyc_q < EN_LAST);
                        // Network output is registered, so its spikes trail net_en by one cycle.
                        if (cyc_q != '0) begin
                            for (int i = 0; i < CLASSES; i++) begin
                                if (spikes[i] && cnt_q[i] != CNT_MAX)
                                    cnt_q[i] <= cnt_q[i] + 1'b1;
                            end
                        end
                        if (cyc_q == CYC_LAST) state <= S_DECIDE;
                    end
                    S_DECIDE: begin
                        winner   <= best_idx;
                        no_spike <= !any_spk;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_DONE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
